// File: rtl/bcu_pkg.sv
// bcu_pkg: condition codes, flag bit positions and FSM state encoding for branch_cond_unit.
`default_nettype none

package bcu_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_NOFLAGS = 2'd0,
    ST_READY   = 2'd1,
    ST_FULL    = 2'd2
  } bcu_state_e;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// cond_eval: combinational condition-code evaluation of {N,Z,C,V} flags.
`default_nettype none

module cond_eval
  import bcu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_code,
  output logic       take
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    take = 1'b0;
    case (cond_code)
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_MI: take = n;
      COND_PL: take = !n;
      COND_VS: take = v;
      COND_VC: take = !v;
      COND_HI: take = c & !z;
      COND_LS: take = !c | z;
      COND_GE: take = (n == v);
      COND_LT: take = (n != v);
      COND_GT: take = !z & (n == v);
      COND_LE: take = z | (n != v);
      COND_AL: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: flag register, request FSM and registered branch-taken result.
// Optional statistics counters enabled by macro BCU_STATS_EN.
`default_nettype none

module branch_cond_unit
  import bcu_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_valid,
  input  logic [3:0]       cmp_flag,
  output logic             cmp_ready,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_ready,
  output logic             take_valid,
  output logic             take,
  input  logic             take_ready,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  bcu_state_e state;
  logic [3:0] flags_q;
  logic [3:0] eff_flags;
  logic       accept;
  logic       eval_take;

  assign cmp_ready = 1'b1;

  always_comb begin
    cond_ready = 1'b0;
    case (state)
      ST_NOFLAGS: cond_ready = (cond_code == COND_AL) || (cond_code == COND_NV);
      ST_READY:   cond_ready = 1'b1;
      ST_FULL:    cond_ready = take_ready;
      default:    cond_ready = 1'b0;
    endcase
  end

  assign accept    = cond_valid & cond_ready;
  // A flag update arriving alongside the request is used directly.
  assign eff_flags = cmp_valid ? cmp_flag : flags_q;

  cond_eval u_cond_eval (
    .flags     (eff_flags),
    .cond_code (cond_code),
    .take      (eval_take)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NOFLAGS;
      flags_q    <= RESET_FLAGS;
      take_valid <= 1'b0;
      take       <= 1'b0;
    end else begin
      if (cmp_valid) flags_q <= cmp_flag;
      if (accept)    take    <= eval_take;
      case (state)
        ST_NOFLAGS: begin
          if (accept) begin
            state      <= ST_FULL;
            take_valid <= 1'b1;
          end else if (cmp_valid) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (accept) begin
            state      <= ST_FULL;
            take_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (take_ready && !accept) begin
            state      <= ST_READY;
            take_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_NOFLAGS;
          take_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (accept) begin
      eval_cnt <= eval_cnt + 1'b1;
      if (eval_take) taken_cnt <= taken_cnt + 1'b1;
    end
  end
`else
  assign eval_cnt  = '0;
  assign taken_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed vectors with a queue-based scoreboard on the result port.
`default_nettype none

module tb_branch_cond_unit;

`ifdef BCU_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmp_valid = 1'b0;
  logic [3:0]       cmp_flag = 4'b0000;
  logic             cmp_ready;
  logic             cond_valid = 1'b0;
  logic [3:0]       cond_code = 4'd0;
  logic             cond_ready;
  logic             take_valid;
  logic             take;
  logic             take_ready = 1'b1;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int errors = 0;
  int checks = 0;
  logic expq[$];

  branch_cond_unit #(.CNT_W(CNT_W), .RESET_FLAGS(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmp_valid  (cmp_valid),
    .cmp_flag   (cmp_flag),
    .cmp_ready  (cmp_ready),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .take_valid (take_valid),
    .take       (take),
    .take_ready (take_ready),
    .eval_cnt   (eval_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one result is consumed per cycle where valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && take_valid && take_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL take_unexpected: got %0b expected none", take);
      end else begin
        logic e;
        e = expq.pop_front();
        if (take !== e) begin
          errors++;
          $display("FAIL take_value: got %0b expected %0b", take, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [3:0] code, input logic exp);
    int n;
    n = 0;
    cond_valid = 1'b1;
    cond_code  = code;
    @(negedge clk);
    while (!cond_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cond_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got cond_ready=0 expected 1 (code %0d)", code);
    end else begin
      expq.push_back(exp);
    end
    step();
    cond_valid = 1'b0;
  endtask

  task automatic setflag(input logic [3:0] f);
    cmp_valid = 1'b1;
    cmp_flag  = f;
    step();
    cmp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    take_ready = 1'b1;
    while ((expq.size() != 0 || take_valid) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (expq.size() != 0 || take_valid) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_take_valid", 64'(take_valid), 64'd0);
    chk("rst_take", 64'(take), 64'd0);
    chk("rst_eval_cnt", 64'(eval_cnt), 64'd0);
    chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("cmp_ready", 64'(cmp_ready), 64'd1);

    cond_valid = 1'b1;
    cond_code  = 4'd0;
    #1;
    chk("noflags_eq_not_ready", 64'(cond_ready), 64'd0);
    @(posedge clk); #1;

    // AL with no flags yet: result one cycle after accept.
    cond_code = 4'd14;
    @(negedge clk);
    chk("noflags_al_ready", 64'(cond_ready), 64'd1);
    expq.push_back(1'b1);
    step();
    cond_valid = 1'b0;
    @(negedge clk);
    chk("latency_take_valid", 64'(take_valid), 64'd1);
    chk("latency_take", 64'(take), 64'd1);
    step();
    req(4'd15, 1'b0);
    drain();

    // 5 vs 9: N set.
    setflag(4'b1000);
    req(4'd11, 1'b1);
    req(4'd10, 1'b0);
    // 10 vs 10: Z and C set.
    setflag(4'b0110);
    req(4'd0, 1'b1);
    req(4'd12, 1'b0);
    req(4'd13, 1'b1);
    req(4'd8, 1'b0);
    req(4'd2, 1'b1);
    req(4'd4, 1'b0);
    drain();

    // Bypass: GT against 6 vs 2 in the same cycle as the flag update.
    cmp_valid = 1'b1;
    cmp_flag  = 4'b0010;
    req(4'd12, 1'b1);
    cmp_valid = 1'b0;
    req(4'd9, 1'b0);
    drain();

    // Stall: held result must not change while flags update underneath.
    take_ready = 1'b0;
    req(4'd0, 1'b0);
    cmp_valid  = 1'b1;
    cmp_flag   = 4'b0100;
    cond_valid = 1'b1;
    cond_code  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cond_ready", 64'(cond_ready), 64'd0);
      chk("stall_take_valid", 64'(take_valid), 64'd1);
      chk("stall_take", 64'(take), 64'd0);
      @(posedge clk); #1;
      cmp_valid = 1'b0;
    end
    take_ready = 1'b1;
    @(negedge clk);
    chk("release_cond_ready", 64'(cond_ready), 64'd1);
    expq.push_back(1'b1);
    step();
    cond_valid = 1'b0;
    drain();

    // Reset while a result is held discards it.
    take_ready = 1'b0;
    req(4'd14, 1'b1);
    rst = 1'b1;
    step();
    void'(expq.pop_back());
    @(negedge clk);
    chk("midrst_take_valid", 64'(take_valid), 64'd0);
    chk("midrst_take", 64'(take), 64'd0);
    rst = 1'b0;
    take_ready = 1'b1;
    cond_valid = 1'b1;
    cond_code  = 4'd3;
    #1;
    chk("midrst_noflags", 64'(cond_ready), 64'd0);
    step();
    cond_valid = 1'b0;

    // Statistics: 17 back-to-back AL accepts.
    do_reset();
    for (int i = 0; i < 17; i++) req(4'd14, 1'b1);
    drain();
    @(negedge clk);
`ifdef BCU_STATS_EN
    chk("stats_eval_cnt", 64'(eval_cnt), 64'd1);
    chk("stats_taken_cnt", 64'(taken_cnt), 64'd1);
`else
    chk("stats_eval_cnt", 64'(eval_cnt), 64'd0);
    chk("stats_taken_cnt", 64'(taken_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
